// File: rtl/score_readout_dual.sv
// ----------------------------------------------------------------------------
// score_readout_dual : walks two score-table banks in global address order and
//                      streams (address, score) entries over a valid/ready port
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module score_readout_dual #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 32,
  parameter int lower_addr1 = 0,
  parameter int upper_addr1 = 9,
  parameter int lower_addr2 = 10,
  parameter int upper_addr2 = 19,
  parameter int SKIP_ZERO   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mem1_data_in,
  input  logic [DATA_WIDTH-1:0] mem2_data_in,
  output logic [ADDR_WIDTH-1:0] mem1_address,
  output logic                  mem1_read_en,
  output logic [ADDR_WIDTH-1:0] mem2_address,
  output logic                  mem2_read_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   out_count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] c_LO1  = ADDR_WIDTH'(lower_addr1);
  localparam logic [ADDR_WIDTH-1:0] c_UP1  = ADDR_WIDTH'(upper_addr1);
  localparam logic [ADDR_WIDTH-1:0] c_LO2  = ADDR_WIDTH'(lower_addr2);
  localparam logic [ADDR_WIDTH-1:0] c_UP2  = ADDR_WIDTH'(upper_addr2);
  localparam bit                    c_SKIP = (SKIP_ZERO != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cursor;
  logic                  r_bank;      // 0 = bank 1, 1 = bank 2
  logic [ADDR_WIDTH-1:0] r_mem1_address;
  logic                  r_mem1_read_en;
  logic [ADDR_WIDTH-1:0] r_mem2_address;
  logic                  r_mem2_read_en;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH:0]   r_out_count;
  logic                  r_busy;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_skip;
  logic                  w_advance;
  logic                  w_adv_done;
  logic                  w_adv_bank;
  logic [ADDR_WIDTH-1:0] w_adv_cursor;

  always_comb begin
    w_rd_data    = r_bank ? mem2_data_in : mem1_data_in;
    w_skip       = c_SKIP && (w_rd_data == '0);
    w_advance    = ((r_state == S_CAPTURE) && w_skip) ||
                   ((r_state == S_PRESENT) && out_ready);
    w_adv_done   = r_bank && (r_cursor == c_UP2);
    w_adv_bank   = r_bank;
    w_adv_cursor = r_cursor + 1'b1;
    if (!r_bank && (r_cursor == c_UP1)) begin
      w_adv_bank   = 1'b1;
      w_adv_cursor = c_LO2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cursor       <= '0;
      r_bank         <= 1'b0;
      r_mem1_address <= '0;
      r_mem1_read_en <= 1'b0;
      r_mem2_address <= '0;
      r_mem2_read_en <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_addr     <= '0;
      r_out_data     <= '0;
      r_out_count    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      // Strobes and addresses are only non-zero for the single ISSUE cycle.
      r_mem1_read_en <= 1'b0;
      r_mem2_read_en <= 1'b0;
      r_mem1_address <= '0;
      r_mem2_address <= '0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cursor       <= c_LO1;
            r_bank         <= 1'b0;
            r_out_count    <= '0;
            r_busy         <= 1'b1;
            r_mem1_read_en <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE:   r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_out_data <= w_rd_data;
          r_out_addr <= r_cursor;
          if (!w_skip) begin
            r_out_valid <= 1'b1;
            r_state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_count <= r_out_count + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_advance) begin
        if (w_adv_done) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_cursor <= w_adv_cursor;
          r_bank   <= w_adv_bank;
          r_state  <= S_ISSUE;
          if (w_adv_bank) begin
            r_mem2_read_en <= 1'b1;
            r_mem2_address <= w_adv_cursor - c_LO2;
          end else begin
            r_mem1_read_en <= 1'b1;
            r_mem1_address <= w_adv_cursor - c_LO1;
          end
        end
      end
    end
  end

  assign mem1_address = r_mem1_address;
  assign mem1_read_en = r_mem1_read_en;
  assign mem2_address = r_mem2_address;
  assign mem2_read_en = r_mem2_read_en;
  assign out_valid    = r_out_valid;
  assign out_addr     = r_out_addr;
  assign out_data     = r_out_data;
  assign out_count    = r_out_count;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_score_readout_dual.sv
// ----------------------------------------------------------------------------
// tb_score_readout_dual : randomized bench for score_readout_dual, one plain
//                         instance and one with zero-score suppression
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_score_readout_dual;

  localparam int AW = 13;
  localparam int DW = 32;

  typedef struct {
    int          a;
    logic [31:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start     [2];
  logic          out_ready [2];
  logic [DW-1:0] rd1 [2];
  logic [DW-1:0] rd2 [2];
  logic [AW-1:0] a1 [2];
  logic [AW-1:0] a2 [2];
  logic          re1 [2];
  logic          re2 [2];
  logic          vld [2];
  logic [AW-1:0] oaddr [2];
  logic [DW-1:0] odata [2];
  logic [AW:0]   ocnt [2];
  logic          bsy [2];
  logic          dn [2];

  logic [31:0] mem [2][20];
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  score_readout_dual u_dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .mem1_data_in(rd1[0]), .mem2_data_in(rd2[0]),
    .mem1_address(a1[0]), .mem1_read_en(re1[0]),
    .mem2_address(a2[0]), .mem2_read_en(re2[0]),
    .out_valid(vld[0]), .out_ready(out_ready[0]),
    .out_addr(oaddr[0]), .out_data(odata[0]), .out_count(ocnt[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  score_readout_dual #(.SKIP_ZERO(1)) u_dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .mem1_data_in(rd1[1]), .mem2_data_in(rd2[1]),
    .mem1_address(a1[1]), .mem1_read_en(re1[1]),
    .mem2_address(a2[1]), .mem2_read_en(re2[1]),
    .out_valid(vld[1]), .out_ready(out_ready[1]),
    .out_addr(oaddr[1]), .out_data(odata[1]), .out_count(ocnt[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  // One-cycle-latency BRAM models; bank 2 local address 0 is global 10.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (re1[d]) rd1[d] <= (a1[d] < 10) ? mem[d][a1[d]] : 'x;
      if (re2[d]) rd2[d] <= (a2[d] < 10) ? mem[d][10 + a2[d]] : 'x;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_valid"}, vld[d], 0);
    chk({tag, "_busy"},  bsy[d], 0);
    chk({tag, "_done"},  dn[d], 0);
    chk({tag, "_re"},    {re1[d], re2[d]}, 0);
    chk({tag, "_maddr"}, {a1[d], a2[d]}, 0);
    chk({tag, "_oaddr"}, oaddr[d], 0);
    chk({tag, "_odata"}, odata[d], 0);
    chk({tag, "_count"}, ocnt[d], 0);
  endtask

  // mode 0: ready always high; 1: random ready + stray starts; 2: 5-cycle stall on addr 4
  task automatic run(input int d, input int mode, input int abort_at);
    ent_t q[$];
    int   exp_rd = 0, acc = 0, dones = 0, cyc, last = -1, stall = 0;
    bit   first = 1'b1, fin = 1'b0, aborted = 1'b0, rdy;
    for (int a = 0; a < 20; a++)
      if (d == 0 || mem[d][a] != 0) q.push_back('{a, mem[d][a]});
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 1;
    while (cyc < 400 && !fin) begin
      if (re1[d] || re2[d]) begin
        chk("rd_one_bank", re1[d] & re2[d], 0);
        chk("rd_order", re1[d] ? a1[d] : a2[d] + 10, exp_rd);
        exp_rd++;
      end else begin
        chk("idle_maddr", {a1[d], a2[d]}, 0);
      end
      if (vld[d]) begin
        chk("rd_in_present", re1[d] | re2[d], 0);
        if (q.size() == 0) chk("extra_entry", 1, 0);
        else begin
          chk("entry_addr", oaddr[d], q[0].a);
          chk("entry_data", odata[d], q[0].d);
        end
        if (first && d == 0) chk("latency", cyc, 3);
        first = 1'b0;
        if (abort_at >= 0 && oaddr[d] == abort_at) begin
          #1 rst_n = 1'b0;
          #1 chk_zero(d, "abort");
          @(negedge clk);
          chk("abort_no_done", dn[d], 0);
          rst_n   = 1'b1;
          aborted = 1'b1;
          break;
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(vld[d] && oaddr[d] == 4 && stall < 5);
          if (!rdy) stall++;
        end
      endcase
      out_ready[d] = rdy;
      if (vld[d] && rdy && q.size() > 0) begin
        acc++;
        void'(q.pop_front());
        if (mode == 0 && d == 0 && last >= 0) chk("throughput", cyc - last, 3);
        last = cyc;
      end
      if (dn[d]) begin
        dones++;
        chk("count_at_done", ocnt[d], acc);
        chk("entries_left", q.size(), 0);
        chk("busy_at_done", bsy[d], 1);
      end else if (dones > 0) begin
        chk("idle_busy", bsy[d], 0);
        chk("count_hold", ocnt[d], acc);
        fin = 1'b1;
      end
      start[d] = (mode == 1 && bsy[d] && !dn[d] && dones == 0) ? 1'($urandom_range(0, 4) == 0) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start[d]     = 1'b0;
    out_ready[d] = 1'b0;
    if (!aborted) begin
      chk("done_once", dones, 1);
      chk("finished_in_time", fin, 1);
      if (mode == 2) chk("stall_cycles", stall, 5);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      out_ready[d] = 1'b0;
      for (int a = 0; a < 20; a++) mem[d][a] = '0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "rst");
    chk_zero(1, "rst_skip");
    rst_n = 1'b1;

    for (int a = 0; a < 20; a++) mem[0][a] = a + 1;
    run(0, 0, -1);
    mem[1][3] = 7; mem[1][12] = 8; mem[1][19] = 9;
    run(1, 0, -1);
    run(0, 2, -1);
    run(0, 1, -1);
    run(0, 0, 14);
    run(0, 0, -1);

    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < 20; a++) begin
        mem[0][a] = $urandom;
        mem[1][a] = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      end
      run(0, 1, -1);
      run(1, 1, -1);
      run(1, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_readout_dual.md
SCORE_READOUT_DUAL -- requirements
Module: score_readout_dual

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 13, score-table address width.
- DATA_WIDTH, 32, score word width.
- lower_addr1, 0, first global address held in bank 1.
- upper_addr1, 9, last global address held in bank 1.
- lower_addr2, 10, first global address held in bank 2.
- upper_addr2, 19, last global address held in bank 2.
- SKIP_ZERO, 0, 1 = suppress entries whose score is 0.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse: begin readout (tie to finished_all).
- mem1_data_in, in, DATA_WIDTH, bank-1 read data, 1-cycle BRAM latency.
- mem2_data_in, in, DATA_WIDTH, bank-2 read data, 1-cycle BRAM latency.
- mem1_address, out, ADDR_WIDTH, bank-1 local address.
- mem1_read_en, out, 1, bank-1 read strobe.
- mem2_address, out, ADDR_WIDTH, bank-2 local address.
- mem2_read_en, out, 1, bank-2 read strobe.
- out_valid, out, 1, entry available.
- out_ready, in, 1, consumer accepts entry.
- out_addr, out, ADDR_WIDTH, global node address of entry.
- out_data, out, DATA_WIDTH, score of entry.
- out_count, out, ADDR_WIDTH+1, entries accepted in current/last readout.
- busy, out, 1, readout in progress.
- done, out, 1, one-cycle pulse at readout end.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, CAPTURE, PRESENT, DONE.
REQ-004 IDLE: start=1 SHALL load cursor=lower_addr1, bank=1, clear out_count, and go to ISSUE next cycle.
REQ-005 ISSUE: the active bank's read_en SHALL be 1 and its address SHALL be cursor minus that bank's lower_addr; the other bank's read_en SHALL be 0; next state CAPTURE.
REQ-006 CAPTURE: the active bank's data_in SHALL be registered into out_data and cursor into out_addr; next state SHALL be PRESENT, or ADVANCE directly if SKIP_ZERO=1 and the data is 0.
REQ-007 PRESENT: out_valid SHALL be 1 and out_addr/out_data SHALL hold stable until the cycle where out_ready=1; that cycle SHALL increment out_count and perform ADVANCE.
REQ-008 ADVANCE, cursor < upper of current bank: cursor+1, go to ISSUE.
REQ-009 ADVANCE, at upper_addr1 in bank 1: cursor=lower_addr2, bank=2, go to ISSUE.
REQ-010 ADVANCE, at upper_addr2 in bank 2: go to DONE.
REQ-011 DONE: done SHALL be 1 for exactly one cycle, then go to IDLE; out_count SHALL hold until the next start.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 out_ready while out_valid=0 SHALL have no effect.
REQ-015 Read strobes SHALL be 0 outside ISSUE, and addresses SHALL be 0 when not issuing.
REQ-016 Latency start->first out_valid SHALL be 3 cycles (IDLE->ISSUE->CAPTURE->PRESENT); with out_ready held 1, throughput SHALL be one entry per 3 cycles.
REQ-017 Block SHALL never write the banks; no write-enable outputs exist.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state IDLE, cursor=0, bank=1, and all outputs to 0 (out_valid, busy, done, read_en, addresses, out_addr, out_data, out_count).
REQ-019 Reset asserted mid-readout SHALL abandon it without a done pulse; after release, a new start SHALL restart from lower_addr1.

Verification
REQ-020 Default params, banks preloaded with score=addr+1, out_ready=1, start pulse -> 20 entries, out_addr 0..19 in order, out_data 1..20, mem2_address 0..9 for addr 10..19, done pulse once, out_count=20.
REQ-021 SKIP_ZERO=1, only addrs 3, 12, 19 nonzero (values 7, 8, 9) -> exactly three entries (3,7), (12,8), (19,9); out_count=3; done pulse.
REQ-022 out_ready low 5 cycles during entry addr 4 -> out_valid, out_addr=4 and out_data stay stable all 5 cycles; no read strobe is issued; entry 5 follows after ready.
REQ-023 Second start pulse while busy -> ignored; sequence and out_count=20 unchanged.
REQ-024 rst_n low while presenting addr 14 -> all outputs 0 immediately, no done; new start -> readout restarts at addr 0.
REQ-025 Boundary: bank 1 ends at 9 -> next ISSUE drives mem2_read_en=1 with mem2_address=0 and mem1_read_en=0.
